// File: rtl/fsm_mealy_pkg.sv
// Shared constants for the 1011 Mealy sequence controller.
// The state encoding and the detected pattern are fixed here.
package fsm_mealy_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S0   = 2'd0;
  localparam state_t S1   = 2'd1;
  localparam state_t S10  = 2'd2;
  localparam state_t S101 = 2'd3;

  localparam logic [3:0] PATTERN = 4'b1011;

endpackage

// File: rtl/fsm_mealy_ctrl_if.sv
// Controller <-> datapath signal bundle.
// Datapath side is the master; the controller is the slave.
interface fsm_mealy_ctrl_if;

  logic d_in;
  logic status;
  logic q_out;
  logic clr;

  modport master (
    output d_in,
    output status,
    input  q_out,
    input  clr
  );

  modport slave (
    input  d_in,
    input  status,
    output q_out,
    output clr
  );

endinterface

// File: rtl/fsm_mealy_ctrl.sv
// Mealy detector for serial pattern 1011 (overlapping) with datapath clear.
// Optional FSM_MEALY_REGOUT_EN registers q_out/clr for one cycle of latency.
module fsm_mealy_ctrl
  import fsm_mealy_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  fsm_mealy_ctrl_if.slave    bus
);

  state_t r_state;
  state_t w_next;
  logic   w_q_out;
  logic   w_clr;

  // Status outranks data; reset forces outputs low so nothing leaks out during it.
  always_comb begin
    w_next  = S0;
    w_q_out = 1'b0;
    w_clr   = 1'b0;
    if (!rst_n) begin
      w_next = S0;
    end else if (bus.status) begin
      w_clr  = 1'b1;
      w_next = S0;
    end else begin
      case (r_state)
        S0:   w_next = bus.d_in ? S1 : S0;
        S1:   w_next = bus.d_in ? S1 : S10;
        S10:  w_next = bus.d_in ? S101 : S0;
        S101: begin
          w_next  = bus.d_in ? S1 : S10;
          w_q_out = bus.d_in;
        end
        default: w_next = S0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S0;
    end else begin
      r_state <= w_next;
    end
  end

`ifdef FSM_MEALY_REGOUT_EN
  logic r_q_out;
  logic r_clr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q_out <= 1'b0;
      r_clr   <= 1'b0;
    end else begin
      r_q_out <= w_q_out;
      r_clr   <= w_clr;
    end
  end

  assign bus.q_out = r_q_out;
  assign bus.clr   = r_clr;
`else
  assign bus.q_out = w_q_out;
  assign bus.clr   = w_clr;
`endif

endmodule

// File: tb/tb_fsm_mealy_ctrl.sv
// Directed self-checking bench for fsm_mealy_ctrl (both FSM_MEALY_REGOUT_EN builds).
// Each step drives one bit after the falling edge and checks outputs before the rising edge.
module tb_fsm_mealy_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  logic prevQ;
  logic prevClr;

  fsm_mealy_ctrl_if bus ();

  fsm_mealy_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // mealyQ/mealyClr are the same-cycle Mealy values; the registered build sees them one step later.
  task automatic applyStimulus(input logic d, input logic s, input logic r,
                               input logic mealyQ, input logic mealyClr, input string tag);
    logic expQ;
    logic expClr;
    @(negedge clk);
    bus.d_in   = d;
    bus.status = s;
    rst_n      = r;
    #1;
`ifdef FSM_MEALY_REGOUT_EN
    expQ   = prevQ;
    expClr = prevClr;
`else
    expQ   = mealyQ;
    expClr = mealyClr;
`endif
    checkOutput({tag, "_q"}, bus.q_out, expQ);
    checkOutput({tag, "_clr"}, bus.clr, expClr);
    prevQ   = mealyQ;
    prevClr = mealyClr;
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    prevQ      = 1'b0;
    prevClr    = 1'b0;
    rst_n      = 1'b0;
    bus.d_in   = 1'b0;
    bus.status = 1'b0;

    // Reset with active inputs: outputs must stay low.
    applyStimulus(1, 1, 0, 0, 0, "rst1");
    applyStimulus(1, 1, 0, 0, 0, "rst2");

    // Basic detect.
    applyStimulus(1, 0, 1, 0, 0, "basic1");
    applyStimulus(0, 0, 1, 0, 0, "basic2");
    applyStimulus(1, 0, 1, 0, 0, "basic3");
    applyStimulus(1, 0, 1, 1, 0, "basic4");

    // Overlap: 1011011 pulses on bits 4 and 7.
    applyStimulus(0, 0, 0, 0, 0, "rstA");
    applyStimulus(1, 0, 1, 0, 0, "ovl1");
    applyStimulus(0, 0, 1, 0, 0, "ovl2");
    applyStimulus(1, 0, 1, 0, 0, "ovl3");
    applyStimulus(1, 0, 1, 1, 0, "ovl4");
    applyStimulus(0, 0, 1, 0, 0, "ovl5");
    applyStimulus(1, 0, 1, 0, 0, "ovl6");
    applyStimulus(1, 0, 1, 1, 0, "ovl7");

    // Near miss: 11101011, only bit 8 fires.
    applyStimulus(0, 0, 0, 0, 0, "rstB");
    applyStimulus(1, 0, 1, 0, 0, "nm1");
    applyStimulus(1, 0, 1, 0, 0, "nm2");
    applyStimulus(1, 0, 1, 0, 0, "nm3");
    applyStimulus(0, 0, 1, 0, 0, "nm4");
    applyStimulus(1, 0, 1, 0, 0, "nm5");
    applyStimulus(0, 0, 1, 0, 0, "nm6");
    applyStimulus(1, 0, 1, 0, 0, "nm7");
    applyStimulus(1, 0, 1, 1, 0, "nm8");

    // Status clear in S101 with d_in=1, then a fresh detect.
    applyStimulus(0, 0, 0, 0, 0, "rstC");
    applyStimulus(1, 0, 1, 0, 0, "st1");
    applyStimulus(0, 0, 1, 0, 0, "st2");
    applyStimulus(1, 0, 1, 0, 0, "st3");
    applyStimulus(1, 1, 1, 0, 1, "stClr");
    applyStimulus(1, 0, 1, 0, 0, "st5");
    applyStimulus(0, 0, 1, 0, 0, "st6");
    applyStimulus(1, 0, 1, 0, 0, "st7");
    applyStimulus(1, 0, 1, 1, 0, "st8");

    // Mid-pattern reset discards progress.
    applyStimulus(0, 0, 0, 0, 0, "rstD");
    applyStimulus(1, 0, 1, 0, 0, "mr1");
    applyStimulus(0, 0, 1, 0, 0, "mr2");
    applyStimulus(1, 0, 1, 0, 0, "mr3");
    applyStimulus(1, 0, 0, 0, 0, "mrRst");
    applyStimulus(1, 0, 1, 0, 0, "mr5");
    applyStimulus(0, 0, 1, 0, 0, "mr6");
    applyStimulus(1, 0, 1, 0, 0, "mr7");
    applyStimulus(1, 0, 1, 1, 0, "mr8");
    applyStimulus(0, 0, 1, 0, 0, "tail");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
